// File: rtl/mips_pkg.sv
// Shared constants for the MEM-stage data-memory access controller.
package mips_pkg;

  localparam int DMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Read data returned on timeout is this bit replicated across the word (all ones).
  localparam logic DMEM_TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts WAIT cycles of one memory access and flags expiry in the TIMEOUT_CYCLES-th cycle.
module dmem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer over a req/ack port; stalls the pipeline until the access completes.
// Optional abort of stuck accesses is enabled by defining DMEM_TIMEOUT_EN.
import mips_pkg::*;

module dmem_access_ctrl #(
  parameter int DATA_WIDTH     = DMEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] alu_resultM,
  input  logic [DATA_WIDTH-1:0] write_dataM,
  output logic                  stallM,
  output logic [DATA_WIDTH-1:0] read_dataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err
);

  dmem_state_t state_reg, state_next;
  logic        op;
  logic        timeout;

  assign op = MemReadM | MemWriteM;

`ifdef DMEM_TIMEOUT_EN
  dmem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg == IDLE),
    .enable (state_reg == WAIT && !mem_ack),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    stallM     = 1'b0;
    case (state_reg)
      IDLE: begin
        stallM = op;
        if (op) state_next = WAIT;
      end
      WAIT: begin
        stallM = 1'b1;
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we doubles as the "this access is a store" flag while waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      read_dataM <= '0;
`ifdef DMEM_TIMEOUT_EN
      mem_err    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef DMEM_TIMEOUT_EN
      mem_err   <= (state_reg == WAIT) && !mem_ack && timeout;
`endif
      case (state_reg)
        IDLE: begin
          if (op) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= alu_resultM;
            mem_wdata <= write_dataM;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) read_dataM <= mem_rdata;
          end else if (timeout) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            read_dataM <= {DATA_WIDTH{DMEM_TIMEOUT_FILL}};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
